// File: rtl/fram_arb_pkg.sv
// Shared types and helpers for the DDR burst-command arbiter.
package fram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2
  } arb_state_e;

  // Channel-index width; a single channel still needs one bit of storage.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fram_cmd_arb_path.sv
// One command path (write or read): grant FSM, address relocation, strobe gating.
// Optional burst watchdog enabled by ARB_WDOG_EN.
//
// state   | meaning
// IDLE    | no grant; arbitrate and latch the winner's command
// REQ     | cmd_en held with the latched address/length until cmd_ready
// BUSY    | command accepted; data phase until cmd_done
module fram_cmd_arb_path
  import fram_arb_pkg::*;
#(
  parameter int CH_NUM      = 4,
  parameter int ADDR_WIDTH  = 28,
  parameter int LEN_WIDTH   = 32,
  parameter int CH_SHIFT    = 25
`ifdef ARB_WDOG_EN
  ,
  parameter int WDOG_CYCLES = 4096
`endif
) (
  input  logic                         ddr_clk,
  input  logic                         ddr_rstn,
  input  logic [CH_NUM-1:0]            ch_req,
  input  logic [CH_NUM*ADDR_WIDTH-1:0] ch_addr,
  input  logic [CH_NUM*LEN_WIDTH-1:0]  ch_len,
  input  logic                         cmd_ready,
  input  logic                         cmd_done,
  output logic                         cmd_en,
  output logic [ADDR_WIDTH-1:0]        cmd_addr,
  output logic [LEN_WIDTH-1:0]         cmd_len,
  output logic [CH_NUM-1:0]            grant,
  output logic                         busy,
  output logic [CH_NUM-1:0]            ch_rdy,
  output logic [CH_NUM-1:0]            ch_done
`ifdef ARB_WDOG_EN
  ,
  output logic                         wdog_err
`endif
);

  localparam int IDX_W = ch_idx_w(CH_NUM);

  arb_state_e              state_q, state_d;
  logic [CH_NUM-1:0]       grant_q;
  logic [ADDR_WIDTH-1:0]   addr_q, sel_addr, reloc_addr;
  logic [LEN_WIDTH-1:0]    len_q, sel_len;
  logic [CH_NUM-1:0]       arb_grant;
  logic [IDX_W-1:0]        arb_idx;
  logic                    arb_any;
  logic                    load, clear;

  rr_arbiter #(.CH_NUM(CH_NUM)) u_rr (
    .ddr_clk (ddr_clk),
    .ddr_rstn(ddr_rstn),
    .req     (ch_req),
    .adv     (load),
    .grant   (arb_grant),
    .idx     (arb_idx),
    .any_req (arb_any)
  );

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        sel_addr = ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len  = ch_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
    // Channel index overwrites its bit field so each channel owns a disjoint region.
    reloc_addr = sel_addr;
    if (CH_NUM > 1) reloc_addr[CH_SHIFT +: IDX_W] = arb_idx;
  end

`ifdef ARB_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_cnt_q;
  logic              wdog_tc;

  assign wdog_tc = (state_q != ST_IDLE) && (wdog_cnt_q == '0);
  assign cmd_en  = (state_q == ST_REQ) && !wdog_tc;

  always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
    if (!ddr_rstn) begin
      wdog_cnt_q <= '0;
    end else if (load) begin
      wdog_cnt_q <= WDOG_W'(WDOG_CYCLES);
    end else if (state_q != ST_IDLE && wdog_cnt_q != '0) begin
      wdog_cnt_q <= wdog_cnt_q - 1'b1;
    end
  end
`else
  assign cmd_en = (state_q == ST_REQ);
`endif

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    clear   = 1'b0;
    ch_rdy  = '0;
    ch_done = '0;
`ifdef ARB_WDOG_EN
    wdog_err = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          load    = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (cmd_en && cmd_ready) begin
          ch_rdy  = grant_q;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cmd_done) begin
          ch_done = grant_q;
          clear   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef ARB_WDOG_EN
    if (wdog_tc) begin
      ch_rdy   = '0;
      ch_done  = grant_q;
      wdog_err = 1'b1;
      clear    = 1'b1;
      state_d  = ST_IDLE;
    end
`endif
  end

  always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
    if (!ddr_rstn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      addr_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        grant_q <= arb_grant;
        addr_q  <= reloc_addr;
        len_q   <= sel_len;
      end else if (clear) begin
        grant_q <= '0;
      end
    end
  end

  assign cmd_addr = addr_q;
  assign cmd_len  = len_q;
  assign grant    = grant_q;
  assign busy     = (state_q == ST_BUSY);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin selector: lowest requesting index strictly after the last grant.
module rr_arbiter
  import fram_arb_pkg::*;
#(
  parameter int CH_NUM = 4
) (
  input  logic                        ddr_clk,
  input  logic                        ddr_rstn,
  input  logic [CH_NUM-1:0]           req,
  input  logic                        adv,
  output logic [CH_NUM-1:0]           grant,
  output logic [ch_idx_w(CH_NUM)-1:0] idx,
  output logic                        any_req
);

  localparam int IDX_W = ch_idx_w(CH_NUM);

  logic [IDX_W-1:0] last_q;

  always_comb begin
    int c;
    c       = 0;
    grant   = '0;
    idx     = '0;
    any_req = 1'b0;
    for (int k = 1; k <= CH_NUM; k++) begin
      c = (int'(last_q) + k) % CH_NUM;
      if (!any_req && req[c]) begin
        any_req  = 1'b1;
        idx      = IDX_W'(c);
        grant[c] = 1'b1;
      end
    end
  end

  // Reset to the top channel so channel 0 wins the first arbitration.
  always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
    if (!ddr_rstn) begin
      last_q <= IDX_W'(CH_NUM - 1);
    end else if (adv) begin
      last_q <= idx;
    end
  end

endmodule

// File: rtl/fram_cmd_arb.sv
// Multi-channel DDR burst-command arbiter: independent round-robin write and read paths.
// Define ARB_WDOG_EN to add the per-path burst watchdog and the wdog_err port.
module fram_cmd_arb
  import fram_arb_pkg::*;
#(
  parameter int CH_NUM      = 4,
  parameter int ADDR_WIDTH  = 28,
  parameter int LEN_WIDTH   = 32,
  parameter int DQ_WIDTH    = 32,
  parameter int CH_SHIFT    = 25,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                           ddr_clk,
  input  logic                           ddr_rstn,
  input  logic [CH_NUM-1:0]              ch_wreq,
  input  logic [CH_NUM*ADDR_WIDTH-1:0]   ch_waddr,
  input  logic [CH_NUM*LEN_WIDTH-1:0]    ch_wr_len,
  input  logic [CH_NUM*8*DQ_WIDTH-1:0]   ch_wdata,
  output logic [CH_NUM-1:0]              ch_wrdy,
  output logic [CH_NUM-1:0]              ch_wdone,
  output logic [CH_NUM-1:0]              ch_wdata_req,
  input  logic [CH_NUM-1:0]              ch_rreq,
  input  logic [CH_NUM*ADDR_WIDTH-1:0]   ch_raddr,
  input  logic [CH_NUM*LEN_WIDTH-1:0]    ch_rd_len,
  output logic [CH_NUM-1:0]              ch_rrdy,
  output logic [CH_NUM-1:0]              ch_rdone,
  output logic [CH_NUM-1:0]              ch_rdata_en,
  output logic [8*DQ_WIDTH-1:0]          ch_rdata,
  output logic                           wr_cmd_en,
  output logic [ADDR_WIDTH-1:0]          wr_cmd_addr,
  output logic [LEN_WIDTH-1:0]           wr_cmd_len,
  input  logic                           wr_cmd_ready,
  input  logic                           wr_cmd_done,
  output logic [8*DQ_WIDTH-1:0]          wr_ctrl_data,
  input  logic                           wr_data_re,
  output logic                           rd_cmd_en,
  output logic [ADDR_WIDTH-1:0]          rd_cmd_addr,
  output logic [LEN_WIDTH-1:0]           rd_cmd_len,
  input  logic                           rd_cmd_ready,
  input  logic                           rd_cmd_done,
  input  logic [8*DQ_WIDTH-1:0]          read_rdata,
  input  logic                           read_en,
  output logic [CH_NUM-1:0]              wr_grant,
  output logic [CH_NUM-1:0]              rd_grant
`ifdef ARB_WDOG_EN
  ,
  output logic [1:0]                     wdog_err
`endif
);

  localparam int DW = 8 * DQ_WIDTH;

  if (CH_NUM < 1 || CH_NUM > 8 || WDOG_CYCLES < 1 ||
      CH_SHIFT + ch_idx_w(CH_NUM) > ADDR_WIDTH) begin : g_bad_cfg
    $error("fram_cmd_arb: unsupported parameter set");
  end

  logic wr_busy, rd_busy;

  fram_cmd_arb_path #(
    .CH_NUM(CH_NUM), .ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH), .CH_SHIFT(CH_SHIFT)
`ifdef ARB_WDOG_EN
    , .WDOG_CYCLES(WDOG_CYCLES)
`endif
  ) u_wr (
    .ddr_clk  (ddr_clk),
    .ddr_rstn (ddr_rstn),
    .ch_req   (ch_wreq),
    .ch_addr  (ch_waddr),
    .ch_len   (ch_wr_len),
    .cmd_ready(wr_cmd_ready),
    .cmd_done (wr_cmd_done),
    .cmd_en   (wr_cmd_en),
    .cmd_addr (wr_cmd_addr),
    .cmd_len  (wr_cmd_len),
    .grant    (wr_grant),
    .busy     (wr_busy),
    .ch_rdy   (ch_wrdy),
    .ch_done  (ch_wdone)
`ifdef ARB_WDOG_EN
    , .wdog_err(wdog_err[0])
`endif
  );

  fram_cmd_arb_path #(
    .CH_NUM(CH_NUM), .ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH), .CH_SHIFT(CH_SHIFT)
`ifdef ARB_WDOG_EN
    , .WDOG_CYCLES(WDOG_CYCLES)
`endif
  ) u_rd (
    .ddr_clk  (ddr_clk),
    .ddr_rstn (ddr_rstn),
    .ch_req   (ch_rreq),
    .ch_addr  (ch_raddr),
    .ch_len   (ch_rd_len),
    .cmd_ready(rd_cmd_ready),
    .cmd_done (rd_cmd_done),
    .cmd_en   (rd_cmd_en),
    .cmd_addr (rd_cmd_addr),
    .cmd_len  (rd_cmd_len),
    .grant    (rd_grant),
    .busy     (rd_busy),
    .ch_rdy   (ch_rrdy),
    .ch_done  (ch_rdone)
`ifdef ARB_WDOG_EN
    , .wdog_err(wdog_err[1])
`endif
  );

  // Data steering is live only in the data phase; the grant is already registered.
  always_comb begin
    wr_ctrl_data = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (wr_busy && wr_grant[i]) wr_ctrl_data = ch_wdata[i*DW +: DW];
    end
  end

  assign ch_wdata_req = wr_busy ? (wr_grant & {CH_NUM{wr_data_re}}) : '0;
  assign ch_rdata_en  = rd_busy ? (rd_grant & {CH_NUM{read_en}})    : '0;
  assign ch_rdata     = rd_busy ? read_rdata : '0;

endmodule

// File: doc/fram_cmd_arb.md
# fram_cmd_arb

Multi-channel DDR burst-command arbiter that lets `CH_NUM` independent write buffers and `CH_NUM` independent read buffers share the single write-command and read-command port of the DDR read/write controller. It sits between the per-channel line buffers and the controller's command/data interface in the frame-buffer subsystem. It provides round-robin grant, per-channel address relocation into disjoint DDR regions, and steering of data-request strobes to the granted channel. Write and read paths arbitrate independently and concurrently.

## Interface
Parameters:
- `CH_NUM`, 4, number of write channels and read channels (1–8).
- `ADDR_WIDTH`, 28, DDR command address width.
- `LEN_WIDTH`, 32, burst-length field width.
- `DQ_WIDTH`, 32, memory DQ width; data bus is `8*DQ_WIDTH`.
- `CH_SHIFT`, 25, bit position of the channel index in the relocated address.
- `WDOG_CYCLES`, 4096, watchdog limit. Used only with `ARB_WDOG_EN`.

Ports:
- `ddr_clk`, in, 1, single clock for all logic.
- `ddr_rstn`, in, 1, asynchronous active-low reset.
- `ch_wreq`, in, `CH_NUM`, per-channel write-burst request.
- `ch_waddr`, in, `CH_NUM*ADDR_WIDTH`, per-channel write address (channel-local).
- `ch_wr_len`, in, `CH_NUM*LEN_WIDTH`, per-channel write length.
- `ch_wdata`, in, `CH_NUM*8*DQ_WIDTH`, per-channel write data.
- `ch_wrdy`, out, `CH_NUM`, command-accepted strobe, granted channel only.
- `ch_wdone`, out, `CH_NUM`, burst-done strobe, granted channel only.
- `ch_wdata_req`, out, `CH_NUM`, data-request strobe, granted channel only.
- `ch_rreq`, `ch_raddr`, `ch_rd_len`, in; `ch_rrdy`, `ch_rdone`, `ch_rdata_en`, out: read equivalents of the above, with the same widths.
- `ch_rdata`, out, `8*DQ_WIDTH`, read data broadcast to all channels.
- `wr_cmd_en`, `wr_cmd_addr`, `wr_cmd_len`, out; `wr_cmd_ready`, `wr_cmd_done`, in: controller write-command port.
- `wr_ctrl_data`, out, `8*DQ_WIDTH`, muxed write data.
- `wr_data_re`, in, 1, controller write-data request.
- `rd_cmd_en`, `rd_cmd_addr`, `rd_cmd_len`, out; `rd_cmd_ready`, `rd_cmd_done`, in: controller read-command port.
- `read_rdata`, in, `8*DQ_WIDTH`; `read_en`, in, 1: controller read data.
- `wr_grant`, `rd_grant`, out, `CH_NUM`, one-hot current grant, or zero when idle.
- `wdog_err`, out, 2, bit0 write / bit1 read watchdog pulse. Present only with `ARB_WDOG_EN`.

## Operation
- Each path runs a 3-state FSM: IDLE → REQ → BUSY → IDLE.
- **IDLE:** if any `ch_*req` is set, the round-robin arbiter selects the lowest-index requesting channel strictly after the last granted channel, wrapping at `CH_NUM-1`. After reset, the last-granted channel is `CH_NUM-1`, so channel 0 wins first. On selection, latch the grant, the address and the length, then go to REQ.
- **Relocated address:** the output address is the channel address with bits `[CH_SHIFT +: clog2(CH_NUM)]` replaced by the channel index. Other bits pass through.
- **REQ:** hold `*_cmd_en` high with the latched address and length. When `*_cmd_en && *_cmd_ready` in the same cycle, pulse `ch_*rdy[g]` and go to BUSY.
- **BUSY:** `*_cmd_en` is low.
  - Write path: `wr_ctrl_data = ch_wdata[g]`; `ch_wdata_req[g] = wr_data_re`.
  - Read path: `ch_rdata_en[g] = read_en`; `ch_rdata = read_rdata`.
  - On `*_cmd_done`, pulse `ch_*done[g]`, clear the grant and go to IDLE.
- **Request drop:** a requester must hold its request until its `rdy` pulse. If the request drops during REQ, the latched command is still issued.
- **Non-granted channels:** `rdy`, `done` and data strobes are always 0.
- **Simultaneous events:** write and read may be in BUSY at once. `*_cmd_done` seen in REQ is ignored.

## Timing
- **Reset values:** every output is 0, both FSMs are in IDLE, and last-grant is `CH_NUM-1`. Reset mid-burst abandons the grant immediately, with no done pulse.
- **Grant latency:** request seen at cycle N → `*_cmd_en` high at N+1.
- **Re-arbitration:** done at cycle M → IDLE at M+1 → next `*_cmd_en` at M+2.
- **Combinational paths:** `ch_*rdy`, `ch_*done`, `ch_wdata_req`, `ch_rdata_en` and `wr_ctrl_data` are combinational from controller inputs, gated by the registered grant (zero added latency). `wr_cmd_*`, `rd_cmd_*` and grants are registered.

## Configuration
- **`ARB_WDOG_EN` defined:**
  - A per-path counter clears on entry to REQ and increments in REQ and BUSY.
  - When it reaches `WDOG_CYCLES`, the FSM forces IDLE, pulses `ch_*done[g]` and the matching `wdog_err` bit for one cycle, and advances last-grant.
- **`ARB_WDOG_EN` undefined:** no counter and no `wdog_err` port. The arbiter waits indefinitely.

## Structure
- **Package `fram_arb_pkg`:** FSM state enum (IDLE/REQ/BUSY) and the `CH_IDX_W = $clog2(CH_NUM)` helper.
- **Sub-module `rr_arbiter`:** parametrised on `CH_NUM`, with request vector and advance strobe in, and one-hot grant plus index out. It is instantiated twice, once for write and once for read.

## Test plan
- **Single channel:** `CH_NUM=4`, `ch_wreq=4'b0100`, addr `0x000_1000` → `wr_cmd_en` 1 cycle later, `wr_cmd_addr=0x400_1000` (`CH_SHIFT=25`), `ch_wrdy[2]` pulse on ready, `ch_wdone[2]` on done.
- **Fairness:** all four write requests held for 8 bursts → grant order 0,1,2,3,0,1,2,3, with 2-cycle done-to-en gap each time.
- **Data steering:** with channel 1 granted, toggle `wr_data_re` → only `ch_wdata_req[1]` follows, and `wr_ctrl_data` equals `ch_wdata[1]`.
- **Concurrency:** write granted to channel 3 and read to channel 0 simultaneously → both commands issue at the same cycle, and `read_en` reaches only `ch_rdata_en[0]`.
- **Reset in BUSY:** `ddr_rstn` low → all outputs 0 the same cycle, no done pulse; after release, channel 0 wins first.
- **Watchdog (`ARB_WDOG_EN`, `WDOG_CYCLES=16`):** `wr_cmd_done` withheld → `wdog_err[0]` and `ch_wdone[g]` pulse 16 cycles after REQ entry, then the next channel is granted.
